// File: rtl/mem_and_wb_pkg.sv
// Shared constants and opcode encoding for the 8-bit core pipeline stages and benches.
package mem_and_wb_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int WB_CNT_W   = 16;

  typedef enum logic [3:0] {
    OP_LDI = 4'd0,
    OP_LDD = 4'd1,
    OP_STD = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } opcode_e;

endpackage

// File: rtl/mem_and_wb_dmem_sp256.sv
// Single-port 256x8 data memory: synchronous write, combinational read of the
// pre-edge contents, so a same-edge read sees the old word (read-before-write).
module dmem_sp256
  import mem_and_wb_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_and_wb.sv
// Memory-access / write-back stage: owns the data memory, returns the register-file
// write port one clock later. Optional memory-mapped I/O port when DMEM_IO_EN is defined.
module mem_and_wb
  import mem_and_wb_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int AW  = ADDR_W,
  parameter int RAW = REG_ADDR_W
`ifdef DMEM_IO_EN
  ,
  parameter logic [AW-1:0] IO_OUT_ADDR = 8'hFF,
  parameter logic [AW-1:0] IO_IN_ADDR  = 8'hFE
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwrite_in,
  input  logic                mem_read_in,
  input  logic                mem_write_in,
  input  logic                mem_to_reg_in,
  input  logic [DW-1:0]       alu_result_in,
  input  logic [DW-1:0]       write_data_to_memory_in,
  input  logic [RAW-1:0]      rd_address_in,
  output logic                regwrite,
  output logic [DW-1:0]       write_data,
  output logic [RAW-1:0]      write_addr,
  output logic [WB_CNT_W-1:0] wb_count
`ifdef DMEM_IO_EN
  ,
  input  logic [DW-1:0]       io_in,
  output logic [DW-1:0]       io_out
`endif
);

  logic                regwrite_q,   regwrite_d;
  logic [DW-1:0]       write_data_q, write_data_d;
  logic [RAW-1:0]      write_addr_q, write_addr_d;
  logic [WB_CNT_W-1:0] wb_count_q,   wb_count_d;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] load_data;
  logic          dmem_we;
  logic          is_load;

  assign mem_addr = alu_result_in[AW-1:0];
  // A store presented while reset is asserted must not land in memory.
  assign dmem_we  = mem_write_in & rst;
  // Illegal read+write resolves to the store; the read is dropped.
  assign is_load  = mem_read_in & mem_to_reg_in & ~mem_write_in;

  dmem_sp256 #(.DW(DW), .AW(AW)) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .addr_i  (mem_addr),
    .wdata_i (write_data_to_memory_in),
    .rdata_o (dmem_rdata)
  );

`ifdef DMEM_IO_EN
  logic [DW-1:0] io_out_q, io_out_d;

  always_comb begin
    load_data = dmem_rdata;
    if (mem_addr == IO_IN_ADDR) load_data = io_in;
    io_out_d = io_out_q;
    if (mem_write_in && (mem_addr == IO_OUT_ADDR)) io_out_d = write_data_to_memory_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) io_out_q <= '0;
    else      io_out_q <= io_out_d;
  end

  assign io_out = io_out_q;
`else
  assign load_data = dmem_rdata;
`endif

  always_comb begin
    regwrite_d   = regwrite_in;
    write_data_d = '0;
    write_addr_d = '0;
    wb_count_d   = wb_count_q;
    if (regwrite_in) begin
      write_addr_d = rd_address_in;
      write_data_d = is_load ? load_data : alu_result_in;
      wb_count_d   = wb_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regwrite_q   <= 1'b0;
      write_data_q <= '0;
      write_addr_q <= '0;
      wb_count_q   <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      write_data_q <= write_data_d;
      write_addr_q <= write_addr_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign regwrite   = regwrite_q;
  assign write_data = write_data_q;
  assign write_addr = write_addr_q;
  assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_mem_and_wb.sv
// Directed bench for mem_and_wb; checks I/O port behaviour when DMEM_IO_EN is defined.
module tb_mem_and_wb;
  import mem_and_wb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  regwrite_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic [DATA_W-1:0]     alu_result_in, write_data_to_memory_in;
  logic [REG_ADDR_W-1:0] rd_address_in;
  logic                  regwrite;
  logic [DATA_W-1:0]     write_data;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [15:0]           wb_count;
  logic [DATA_W-1:0]     io_in;
  logic [DATA_W-1:0]     io_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_and_wb dut (
    .clk                     (clk),
    .rst                     (rst),
    .regwrite_in             (regwrite_in),
    .mem_read_in             (mem_read_in),
    .mem_write_in            (mem_write_in),
    .mem_to_reg_in           (mem_to_reg_in),
    .alu_result_in           (alu_result_in),
    .write_data_to_memory_in (write_data_to_memory_in),
    .rd_address_in           (rd_address_in),
    .regwrite                (regwrite),
    .write_data              (write_data),
    .write_addr              (write_addr),
    .wb_count                (wb_count)
`ifdef DMEM_IO_EN
    ,
    .io_in                   (io_in),
    .io_out                  (io_out)
`endif
  );

`ifndef DMEM_IO_EN
  assign io_out = '0;
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one instruction, clock it in, then settle just after the edge.
  task automatic step(input logic r, input logic rw, input logic mr, input logic mw,
                      input logic m2r, input logic [7:0] alu, input logic [7:0] wd,
                      input logic [2:0] rd);
    rst = r; regwrite_in = rw; mem_read_in = mr; mem_write_in = mw;
    mem_to_reg_in = m2r; alu_result_in = alu; write_data_to_memory_in = wd;
    rd_address_in = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic rw, input logic [7:0] wd,
                          input logic [2:0] wa, input logic [15:0] cnt);
    check({tag, ".regwrite"},   {15'd0, regwrite},   {15'd0, rw});
    check({tag, ".write_data"}, {8'd0, write_data},  {8'd0, wd});
    check({tag, ".write_addr"}, {13'd0, write_addr}, {13'd0, wa});
    check({tag, ".wb_count"},   wb_count,            cnt);
  endtask

  initial begin
    io_in = 8'h00;
    //   rst rw mr mw m2r alu    wdata  rd
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0);
    check_wb("reset", 0, 8'h00, 3'd0, 16'd0);
    check("reset.io_out", {8'd0, io_out}, 16'd0);

    step(1, 0, 0, 1, 0, 8'h02, 8'h01, 3'd5);
    check_wb("bubble_store", 0, 8'h00, 3'd0, 16'd0);

    step(1, 1, 0, 0, 0, 8'h34, 8'h00, 3'd2);
    check_wb("alu_pass", 1, 8'h34, 3'd2, 16'd1);

    step(1, 0, 0, 1, 0, 8'h01, 8'h33, 3'd0);
    check_wb("std1", 0, 8'h00, 3'd0, 16'd1);

    step(1, 1, 1, 0, 1, 8'h01, 8'h00, 3'd4);
    check_wb("ldd1_after_std", 1, 8'h33, 3'd4, 16'd2);

    step(1, 1, 1, 0, 1, 8'h02, 8'h00, 3'd3);
    check_wb("ldd2_untouched", 1, 8'h01, 3'd3, 16'd3);

    step(1, 0, 0, 1, 0, 8'h05, 8'hAA, 3'd0);
    check_wb("std5", 0, 8'h00, 3'd0, 16'd3);

    step(0, 1, 0, 1, 0, 8'h05, 8'h77, 3'd5);
    check_wb("reset_mid", 0, 8'h00, 3'd0, 16'd0);

    step(1, 1, 1, 0, 1, 8'h05, 8'h00, 3'd1);
    check_wb("ldd5_store_dropped", 1, 8'hAA, 3'd1, 16'd1);

    step(1, 1, 1, 1, 1, 8'h07, 8'h55, 3'd6);
    check_wb("illegal_rw", 1, 8'h07, 3'd6, 16'd2);

    step(1, 1, 1, 0, 1, 8'h07, 8'h00, 3'd7);
    check_wb("ldd7_after_illegal", 1, 8'h55, 3'd7, 16'd3);

    step(1, 1, 0, 0, 1, 8'h9A, 8'h00, 3'd5);
    check_wb("m2r_no_read", 1, 8'h9A, 3'd5, 16'd4);

    step(1, 1, 1, 0, 0, 8'h3C, 8'h00, 3'd2);
    check_wb("read_no_m2r", 1, 8'h3C, 3'd2, 16'd5);

    step(1, 0, 0, 1, 0, 8'hFF, 8'hC3, 3'd0);
`ifdef DMEM_IO_EN
    check("io_out_store", {8'd0, io_out}, 16'h00C3);
`endif

    step(1, 1, 1, 0, 1, 8'hFF, 8'h00, 3'd2);
    check_wb("ldd_ff", 1, 8'hC3, 3'd2, 16'd6);

    step(1, 0, 0, 1, 0, 8'hFE, 8'h11, 3'd0);
    io_in = 8'h5A;
    step(1, 1, 1, 0, 1, 8'hFE, 8'h00, 3'd3);
`ifdef DMEM_IO_EN
    check_wb("ldd_fe_io", 1, 8'h5A, 3'd3, 16'd7);
`else
    check_wb("ldd_fe_mem", 1, 8'h11, 3'd3, 16'd7);
`endif

    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0);
    check("wrap_reset.wb_count", wb_count, 16'd0);
    check("wrap_reset.io_out", {8'd0, io_out}, 16'd0);
    rst = 1'b1; regwrite_in = 1'b1; alu_result_in = 8'h00; rd_address_in = 3'd1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    check("wrap.max", wb_count, 16'hFFFF);
    step(1, 1, 0, 0, 0, 8'h00, 8'h00, 3'd1);
    check("wrap.zero", wb_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
